// File: rtl/crop_ctrl.sv
// crop_ctrl: frame sequencer that gates camera pixels into crop_filter one frame at a time,
// generates beat coordinates and latches the clamped crop origin at frame boundaries.
module crop_ctrl #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int IN_ROWS = 20,
  parameter int IN_COLS = 20,
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10
) (
  input  logic clk,
  input  logic s_axis_resetn,
  input  logic ap_start,
  input  logic ap_continuous,
  output logic ap_ready,
  output logic ap_idle,
  output logic ap_done,
  input  logic cfg_wr,
  input  logic [$clog2(IN_COLS)-1:0] cfg_crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0] cfg_crop_y0,
  output logic cf_ap_start,
  input  logic cf_ap_ready,
  input  logic cf_ap_done,
  output logic [$clog2(IN_COLS)-1:0] crop_x0,
  output logic [$clog2(IN_ROWS)-1:0] crop_y0,
  output logic [$clog2(IN_COLS)-1:0] cnt_col,
  output logic [$clog2(IN_ROWS)-1:0] cnt_row,
  input  logic s_axis_tvalid,
  output logic s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  output logic m_axis_tvalid,
  input  logic m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
  output logic clamp_err,
  output logic [15:0] frame_cnt
);
  localparam int CW = $clog2(IN_COLS);
  localparam int RW = $clog2(IN_ROWS);
  localparam logic [CW:0] MAX_X = (CW+1)'(IN_COLS - OUT_COLS);
  localparam logic [RW:0] MAX_Y = (RW+1)'(IN_ROWS - OUT_ROWS);
  typedef enum logic [2:0] {IDLE, ARM, RUN, FLUSH, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] sh_x;
  logic [RW-1:0] sh_y;
  logic cf_seen, run_gate, beat, last_col, last_beat, arm_entry, clr_x, clr_y;
  assign run_gate = state == RUN;
  assign m_axis_tvalid = s_axis_tvalid && run_gate;
  assign s_axis_tready = m_axis_tready && run_gate;
  assign m_axis_tdata = s_axis_tdata;
  assign beat = m_axis_tvalid && m_axis_tready;
  assign last_col = cnt_col == CW'(IN_COLS - 1);
  assign last_beat = beat && last_col && cnt_row == RW'(IN_ROWS - 1);
  assign ap_idle = state == IDLE;
  assign ap_ready = ap_idle;
  assign ap_done = state == DONE;
  assign cf_ap_start = state == ARM && cf_ap_ready;
  assign arm_entry = nxt == ARM && state != ARM;
  // compare one bit wider so a shadow value above the limit can never wrap below it
  assign clr_x = {1'b0, sh_x} > MAX_X;
  assign clr_y = {1'b0, sh_y} > MAX_Y;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = ap_start ? ARM : IDLE;
      ARM:     nxt = cf_ap_ready ? RUN : ARM;
      RUN:     nxt = last_beat ? FLUSH : RUN;
      FLUSH:   nxt = cf_seen ? DONE : FLUSH;
      DONE:    nxt = ap_continuous ? ARM : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge s_axis_resetn)
    if (!s_axis_resetn) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge s_axis_resetn)
    if (!s_axis_resetn) begin
      sh_x <= '0;
      sh_y <= '0;
      crop_x0 <= '0;
      crop_y0 <= '0;
      clamp_err <= 1'b0;
      cnt_col <= '0;
      cnt_row <= '0;
      cf_seen <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (cfg_wr) begin
        sh_x <= cfg_crop_x0;
        sh_y <= cfg_crop_y0;
      end
      if (arm_entry) begin
        crop_x0 <= clr_x ? MAX_X[CW-1:0] : sh_x;
        crop_y0 <= clr_y ? MAX_Y[RW-1:0] : sh_y;
        clamp_err <= clr_x || clr_y;
        cnt_col <= '0;
        cnt_row <= '0;
        cf_seen <= 1'b0;
      end else begin
        if (beat) begin
          cnt_col <= last_col ? '0 : cnt_col + 1'b1;
          if (last_col) cnt_row <= last_beat ? '0 : cnt_row + 1'b1;
        end
        if ((state == RUN || state == FLUSH) && cf_ap_done) cf_seen <= 1'b1;
      end
      if (state == DONE) frame_cnt <= frame_cnt + 1'b1;
    end
endmodule

// File: tb/tb_crop_ctrl.sv
// tb_crop_ctrl: randomized frame-level bench for crop_ctrl against a beat-index reference model.
module tb_crop_ctrl;
  logic clk = 1'b0;
  logic rstn, ap_start, ap_cont, ap_ready, ap_idle, ap_done, cfg_wr;
  logic cf_ap_start, cf_ap_ready, cf_ap_done, clamp_err;
  logic [4:0] cfg_x, cfg_y, crop_x0, crop_y0, cnt_col, cnt_row;
  logic s_tvalid, s_tready, m_tvalid, m_tready;
  logic [9:0] s_tdata, m_tdata;
  logic [15:0] frame_cnt;
  int total = 0, bad = 0;
  int sh_x = 0, sh_y = 0, fc = 0;
  bit pend = 0;
  int pend_x, pend_y;

  always #5 clk = ~clk;

  crop_ctrl #(.PIXEL_BIT_WIDTH(10), .IN_ROWS(20), .IN_COLS(20), .OUT_ROWS(10), .OUT_COLS(10)) dut (
    .clk(clk), .s_axis_resetn(rstn), .ap_start(ap_start), .ap_continuous(ap_cont),
    .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_done(ap_done), .cfg_wr(cfg_wr),
    .cfg_crop_x0(cfg_x), .cfg_crop_y0(cfg_y), .cf_ap_start(cf_ap_start),
    .cf_ap_ready(cf_ap_ready), .cf_ap_done(cf_ap_done), .crop_x0(crop_x0), .crop_y0(crop_y0),
    .cnt_col(cnt_col), .cnt_row(cnt_row), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .clamp_err(clamp_err), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic quiet();
    ap_start = 0; cfg_wr = 0; cf_ap_ready = 0; cf_ap_done = 0;
    s_tvalid = 0; m_tready = 0; s_tdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, ap_ready, 1);
    chk({tag, "_idle"}, ap_idle, 1);
    chk({tag, "_done"}, ap_done, 0);
    chk({tag, "_cfstart"}, cf_ap_start, 0);
    chk({tag, "_mvalid"}, m_tvalid, 0);
    chk({tag, "_sready"}, s_tready, 0);
    chk({tag, "_col"}, cnt_col, 0);
    chk({tag, "_row"}, cnt_row, 0);
    chk({tag, "_cropx"}, crop_x0, 0);
    chk({tag, "_cropy"}, crop_y0, 0);
    chk({tag, "_clamp"}, clamp_err, 0);
    chk({tag, "_fcnt"}, frame_cnt, 0);
  endtask

  task automatic cfg(input int x, input int y);
    @(negedge clk);
    cfg_wr = 1; cfg_x = 5'(x); cfg_y = 5'(y);
    sh_x = x; sh_y = y;
    @(negedge clk);
    cfg_wr = 0;
  endtask

  // ap_start pulse, optionally with a shadow write in the very same cycle
  task automatic go(input bit w, input int x, input int y);
    @(negedge clk);
    ap_start = 1; cfg_wr = w; cfg_x = 5'(x); cfg_y = 5'(y);
    if (w) begin pend = 1; pend_x = x; pend_y = y; end
    @(negedge clk);
    ap_start = 0; cfg_wr = 0;
    #1 chk("arm_entry_idle", ap_idle, 0);
  endtask

  task automatic frame(input bit bp, input int nready, input int wr_at, input int wx,
                       input int wy, input int abort_at);
    int ex, ey, ee, k, cyc, starts, dly;
    bit tog, coinc, done_seen;
    ex = sh_x < 10 ? sh_x : 10;
    ey = sh_y < 10 ? sh_y : 10;
    ee = (sh_x > 10 || sh_y > 10) ? 1 : 0;
    if (pend) begin sh_x = pend_x; sh_y = pend_y; pend = 0; end
    starts = 0; cyc = 0;
    while (starts == 0 && cyc < 200) begin
      @(negedge clk);
      cf_ap_ready = cyc >= nready;
      s_tvalid = 1; m_tready = 1;
      #1;
      chk("arm_cfstart", cf_ap_start, cyc >= nready ? 1 : 0);
      if (cf_ap_start) starts = 1;
      else begin
        chk("arm_sready", s_tready, 0);
        chk("arm_mvalid", m_tvalid, 0);
        chk("arm_idle", ap_idle, 0);
        cyc++;
      end
    end
    chk("start_seen", starts, 1);
    chk("crop_x0", crop_x0, ex);
    chk("crop_y0", crop_y0, ey);
    chk("clamp_err", clamp_err, ee);
    k = 0; cyc = 0; tog = 0;
    coinc = 1'($urandom_range(0, 1));
    while (k < 400 && cyc < 4000) begin
      @(negedge clk);
      cf_ap_ready = 0;
      if (k == wr_at) begin
        cfg_wr = 1; cfg_x = 5'(wx); cfg_y = 5'(wy); sh_x = wx; sh_y = wy;
      end else cfg_wr = 0;
      s_tvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_tready = bp ? tog : 1'b1;
      tog = ~tog;
      s_tdata = 10'($urandom);
      cf_ap_done = coinc && k == 399 && s_tvalid && m_tready;
      #1;
      chk("run_mvalid", m_tvalid, s_tvalid);
      chk("run_sready", s_tready, m_tready);
      chk("run_tdata", m_tdata, s_tdata);
      chk("run_cfstart", cf_ap_start, 0);
      if (s_tvalid && m_tready) begin
        chk("cnt_col", cnt_col, k % 20);
        chk("cnt_row", cnt_row, k / 20);
        k++;
        if (k == abort_at) begin
          rstn = 0;
          #1 check_reset_outputs("async_rst");
          @(negedge clk);
          quiet();
          rstn = 1;
          sh_x = 0; sh_y = 0; fc = 0;
          return;
        end
      end
      cyc++;
    end
    chk("beats", k, 400);
    cfg_wr = 0;
    dly = $urandom_range(0, 3);
    cyc = 0; done_seen = 0;
    while (!done_seen && cyc < 50) begin
      @(negedge clk);
      cf_ap_done = !coinc && cyc == dly;
      s_tvalid = 1; m_tready = 1;
      #1;
      chk("flush_sready", s_tready, 0);
      if (ap_done) done_seen = 1;
      else cyc++;
    end
    chk("done_seen", done_seen, 1);
    chk("done_latency", cyc, coinc ? 1 : dly + 2);
    fc = (fc + 1) & 16'hFFFF;
    @(negedge clk);
    quiet();
    #1;
    chk("done_pulse", ap_done, 0);
    chk("frame_cnt", frame_cnt, fc);
    chk("post_idle", ap_idle, ap_cont ? 0 : 1);
    chk("clamp_hold", clamp_err, ee);
  endtask

  initial begin
    quiet();
    ap_cont = 0; cfg_x = '0; cfg_y = '0;
    rstn = 1;
    #1 rstn = 0;
    #2 check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1;
    cfg(3, 5);
    go(0, 0, 0);
    frame(0, 0, -1, 0, 0, -1);
    cfg(15, 12);
    go(0, 0, 0);
    frame(0, 0, -1, 0, 0, -1);
    cfg(10, 0);
    go(0, 0, 0);
    frame(1, 0, -1, 0, 0, -1);
    go(0, 0, 0);
    frame(0, 8, -1, 0, 0, -1);
    go(1, 2, 4);
    frame(1, 0, -1, 0, 0, -1);
    ap_cont = 1;
    go(0, 0, 0);
    frame(0, 0, 137, 7, 0, -1);
    ap_cont = 0;
    frame(1, 3, -1, 0, 0, -1);
    chk("cont_frames", frame_cnt, 7);
    go(0, 0, 0);
    frame(0, 0, -1, 0, 0, 137);
    go(0, 0, 0);
    frame(0, 0, -1, 0, 0, -1);
    chk("after_reset_fcnt", frame_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
